// File: rtl/add_seq_pkg.sv
// Shared constants and state encoding for the slice-serial 64-bit adder.
// No logic here; imported by add64_seq.
// Slice geometry is fixed at 4 x 16 bits.
package add_seq_pkg;

    localparam int WIDTH = 16;
    localparam int WORDS = 4;
    localparam int IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add16.sv
// 16-bit ripple adder slice with carry in/out.
// Latency: purely combinational.
// Backpressure: none.
module add16 (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    output logic [15:0] Sum,
    output logic        Cout
);

    assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {16'd0, Cin};

endmodule

// File: rtl/add64_seq.sv
// 64-bit add/subtract computed by one 16-bit adder over four slices, LS slice first.
// Latency: start accepted at edge t -> done high in the cycle after edge t+4.
// Backpressure: start is ignored while busy; no queuing.
module add64_seq #(
    parameter int WIDTH = add_seq_pkg::WIDTH,
    parameter int WORDS = add_seq_pkg::WORDS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [WIDTH*WORDS-1:0]   A,
    input  logic [WIDTH*WORDS-1:0]   B,
    input  logic                     Cin,
    input  logic                     Sub,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH*WORDS-1:0]   Sum,
    output logic                     Cout,
    output logic                     Overflow
);

    import add_seq_pkg::*;

    localparam int N   = WIDTH * WORDS;
    localparam int MSB = N - 1;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [N-1:0]     a_r, b_r, sum_r;
    logic             cout_r, ovf_r;
    logic [WIDTH-1:0] a_sl, b_sl, s_sl;
    logic             c_sl;
    logic             last;

    assign last = (idx == IDX_W'(WORDS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Slice multiplexers feeding the single shared adder.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (idx == IDX_W'(w)) begin
                a_sl = a_r[w*WIDTH +: WIDTH];
                b_sl = b_r[w*WIDTH +: WIDTH];
            end
        end
    end

    add16 u_add16 (
        .A    (a_sl),
        .B    (b_sl),
        .Cin  (carry),
        .Sum  (s_sl),
        .Cout (c_sl)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx    <= '0;
            carry  <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= A;
                        b_r   <= Sub ? ~B : B;
                        carry <= Sub | Cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    for (int w = 0; w < WORDS; w++) begin
                        if (idx == IDX_W'(w)) sum_r[w*WIDTH +: WIDTH] <= s_sl;
                    end
                    carry <= c_sl;
                    idx   <= last ? '0 : idx + 1'b1;
                    // Top slice result is still on the adder output here, not yet in sum_r.
                    if (last) begin
                        cout_r <= c_sl;
                        ovf_r  <= (a_r[MSB] == b_r[MSB]) && (s_sl[WIDTH-1] != a_r[MSB]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign Sum      = sum_r;
    assign Cout     = cout_r;
    assign Overflow = ovf_r;

endmodule

// File: tb/tb_add64_seq.sv
// Directed-vector bench for add64_seq: table of operations plus hand-written
// sequences for re-start during RUN, reset abort and continuous start.
module tb_add64_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] A, B;
    logic        Cin, Sub;
    logic        busy, done;
    logic [63:0] Sum;
    logic        Cout, Overflow;

    int n_vec = 0;
    int n_err = 0;

    add64_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .A        (A),
        .B        (B),
        .Cin      (Cin),
        .Sub      (Sub),
        .busy     (busy),
        .done     (done),
        .Sum      (Sum),
        .Cout     (Cout),
        .Overflow (Overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        sub;
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vt[11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Caller is #1 after a posedge with the DUT idle. Returns edges from acceptance to done.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                          input logic cin, input logic sub, output int lat);
        A = a; B = b; Cin = cin; Sub = sub; start = 1'b1;
        step();
        start = 1'b0;
        A = {$urandom, $urandom};
        B = {$urandom, $urandom};
        Cin = 1'($urandom);
        Sub = 1'($urandom);
        lat = 0;
        while (!done && lat < 20) begin
            step();
            lat++;
        end
    endtask

    int lat, pulses, k;

    initial begin
        vt[0]  = '{64'd1, 64'd2, 1'b0, 1'b0, 64'd3, 1'b0, 1'b0};
        vt[1]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0};
        vt[2]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vt[3]  = '{64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vt[4]  = '{64'h1234, 64'h1234, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0};
        vt[5]  = '{64'h0000_0000_0000_FFFF, 64'd0, 1'b1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
        vt[6]  = '{64'd10, 64'd3, 1'b1, 1'b1, 64'd7, 1'b1, 1'b0};
        vt[7]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1};
        vt[8]  = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        vt[9]  = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0,
                   64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
        vt[10] = '{64'h0000_FFFF_0000_0000, 64'h0000_0001_0000_0000, 1'b0, 1'b0,
                   64'h0001_0000_0000_0000, 1'b0, 1'b0};

        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
        step();
        step();
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset sum", Sum, 64'd0);
        chk("reset cout", 64'(Cout), 64'd0);
        chk("reset ovf", 64'(Overflow), 64'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 11; i++) begin
            n_vec++;
            run_op(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, lat);
            chk($sformatf("v%0d latency", i), 64'(lat), 64'd4);
            chk($sformatf("v%0d sum", i), Sum, vt[i].sum);
            chk($sformatf("v%0d cout", i), 64'(Cout), 64'(vt[i].cout));
            chk($sformatf("v%0d ovf", i), 64'(Overflow), 64'(vt[i].ovf));
            step();
            chk($sformatf("v%0d done pulse width", i), 64'(done), 64'd0);
            chk($sformatf("v%0d idle busy", i), 64'(busy), 64'd0);
            chk($sformatf("v%0d sum hold", i), Sum, vt[i].sum);
            chk($sformatf("v%0d cout hold", i), 64'(Cout), 64'(vt[i].cout));
        end

        // Start re-pulsed during RUN with other operands must be ignored.
        n_vec++;
        A = 64'd1; B = 64'd2; Cin = 1'b0; Sub = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("restart busy", 64'(busy), 64'd1);
        A = 64'h5555_5555_5555_5555; B = 64'h1111_1111_1111_1111; Sub = 1'b1; start = 1'b1;
        step();
        step();
        start = 1'b0;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            if (done) begin
                pulses++;
                chk("restart sum", Sum, 64'd3);
                chk("restart cout", 64'(Cout), 64'd0);
            end
            step();
        end
        chk("restart pulses", 64'(pulses), 64'd1);
        chk("restart final sum", Sum, 64'd3);

        // Reset in the second RUN cycle aborts; reset beats start; first released edge accepts.
        n_vec++;
        A = 64'hFFFF_FFFF_FFFF_FFFF; B = 64'd1; Cin = 1'b0; Sub = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        chk("abort sum", Sum, 64'd0);
        chk("abort cout", 64'(Cout), 64'd0);
        start = 1'b1;
        A = 64'h7FFF_FFFF_FFFF_FFFF; B = 64'd1;
        step();
        chk("reset priority busy", 64'(busy), 64'd0);
        chk("reset priority done", 64'(done), 64'd0);
        rst_n = 1'b1;
        step();
        start = 1'b0;
        chk("first edge accept busy", 64'(busy), 64'd1);
        lat = 0;
        while (!done && lat < 20) begin
            step();
            lat++;
        end
        chk("post-reset latency", 64'(lat), 64'd4);
        chk("post-reset sum", Sum, 64'h8000_0000_0000_0000);
        chk("post-reset ovf", 64'(Overflow), 64'd1);
        step();

        // Start held high: a new operation every 6 cycles.
        n_vec++;
        A = 64'd40; B = 64'd2; Cin = 1'b1; Sub = 1'b0; start = 1'b1;
        lat = 0;
        while (!done && lat < 20) begin
            step();
            lat++;
        end
        chk("cont first latency", 64'(lat), 64'd5);
        chk("cont first sum", Sum, 64'd43);
        k = 0;
        do begin
            step();
            k++;
        end while (!done && k < 20);
        chk("cont period", 64'(k), 64'd6);
        chk("cont second sum", Sum, 64'd43);
        start = 1'b0;
        step();
        chk("cont stop busy", 64'(busy), 64'd0);
        step();
        chk("cont stays idle", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/add64_seq.md
ADD64_SEQ -- requirements
Module: add64_seq

Interface
REQ-001 The block SHALL have exactly one clock, clk; reset rst_n SHALL be synchronous and active-low.
REQ-002 Ports SHALL be, in order:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request pulse, sampled only in IDLE
- A  in  64  operand A, captured on accepted start
- B  in  64  operand B, captured on accepted start
- Cin  in  1  carry-in, captured on accepted start
- Sub  in  1  1 = subtract (A + ~B + 1; Cin ignored), captured on accepted start
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle completion pulse
- Sum  out  64  result, registered
- Cout  out  1  carry out of bit 63, registered
- Overflow  out  1  signed overflow, registered
REQ-003 Parameters SHALL be WIDTH, default 16, adder slice width; WORDS, default 4, slices per operation.

Function
REQ-004 The block SHALL compute the 64-bit sum by time-multiplexing one 16-bit adder over four slices, least significant slice first.
REQ-005 States SHALL be IDLE, RUN and DONE.
REQ-006 Transitions SHALL be:
- IDLE to RUN on start=1, capturing A, B' (B or ~B per Sub) and carry (Cin, or 1 if Sub), and clearing the slice index to 0.
- RUN to RUN while the slice index is below 3.
- RUN to DONE after slice 3.
- DONE to IDLE unconditionally.
REQ-007 In each RUN cycle the block SHALL:
- add slice[idx] of A and B' with the carry register;
- write the 16-bit result into Sum[16*idx+15:16*idx];
- load the carry register from the adder carry-out;
- increment idx.
REQ-008 Latency: with start accepted at edge t, done SHALL be high for exactly the cycle following edge t+4 (4 RUN cycles).
REQ-009 At DONE, Cout SHALL equal the slice-3 carry-out.
REQ-010 At DONE, Overflow SHALL equal (A[63]==B'[63]) && (Sum[63]!=A[63]).
REQ-011 Sum, Cout and Overflow SHALL hold their DONE values until the next accepted start.
REQ-012 Slices of Sum MAY update during RUN; they are valid only while done is high and afterwards.
REQ-013 Start SHALL be ignored while busy=1: no recapture, no queuing, and no effect on the in-flight result.
REQ-014 Start held high continuously SHALL begin a new operation on each return to IDLE, with a period of 6 cycles.
REQ-015 Changes to A, B, Cin and Sub after capture SHALL NOT affect the in-flight result.
REQ-016 Arithmetic SHALL be modulo 2^64; the carry out of slice 3 SHALL NOT wrap into slice 0.

Reset
REQ-017 On a clk edge with rst_n=0, the state SHALL become IDLE, and busy, done, Sum, Cout, Overflow, idx and the carry register SHALL all become 0.
REQ-018 Reset asserted during RUN or DONE SHALL abort the operation with no done pulse.
REQ-019 Reset SHALL take priority over a simultaneous start.
REQ-020 Start SHALL be accepted on the first edge with rst_n=1.

Structure
REQ-021 Package add_seq_pkg SHALL hold the state enum (IDLE, RUN, DONE), WIDTH=16, WORDS=4, and the index width of 2 bits.
REQ-022 Exactly one sub-module SHALL be instantiated: the existing add16 (A, B, Cin, Sum, Cout), fed by the slice multiplexers.
REQ-023 The block SHALL contain no second adder and no combinational path from inputs to outputs.

Verification
REQ-024 A=1, B=2, Cin=0, Sub=0 -> done after 5 cycles, Sum=3, Cout=0, Overflow=0.
REQ-025 A=0xFFFF_FFFF_FFFF_FFFF, B=1, Cin=0 -> Sum=0, Cout=1, Overflow=0; the carry ripples through all 4 slices.
REQ-026 A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> Sum=0x8000_0000_0000_0000, Overflow=1, Cout=0.
REQ-027 Sub=1, A=5, B=7 -> Sum=0xFFFF_FFFF_FFFF_FFFE, Cout=0, Overflow=0; a second Sub=1 run with A=B=0x1234 -> Sum=0, Cout=1.
REQ-028 Start re-pulsed in RUN with different operands -> ignored; the first result is unchanged and exactly one done pulse occurs.
REQ-029 rst_n=0 at the second RUN cycle -> next cycle busy=0, Sum=0, no done; a fresh start then gives the correct result after 5 cycles.
